i2c_slave_rx: RTL

//  Write-only I2C target: receives the serial SCL/SDA stream produced by the I2C master and returns bytes.

---
 rtl/i2c_slave_rx_pkg.sv | 24 ++
 rtl/i2c_slave_rx_sync_edge.sv | 32 +++
 rtl/i2c_slave_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/i2c_slave_rx_pkg.sv
// Shared definitions for the write-only I2C target: FSM state encoding,
// bus-level constants and the address-match helper.
package i2c_slave_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } state_e;

    localparam logic       I2C_ACK       = 1'b0;
    localparam logic       I2C_NACK      = 1'b1;
    localparam logic       RW_WRITE      = 1'b0;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (addr_byte[0] == RW_WRITE);
    endfunction

endpackage

// File: rtl/i2c_slave_rx_sync_edge.sv
// Synchronizer plus one delay flop for an asynchronous bus line; provides the
// synchronized level and single-cycle rise/fall pulses.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // Reset to the idle-high bus level so that leaving reset creates no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            dly_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~dly_q;
    assign fall_o  = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: detects START/STOP, matches a 7-bit address, ACKs
// address and data bytes, and strobes each received data byte out.
module i2c_slave_rx
    import i2c_slave_rx_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       addr_hit
);

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    state_e     state_q,    state_d;
    logic [3:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] shift_q,    shift_d;
    logic       sda_oe_q,   sda_oe_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q,     busy_d;
    logic       addr_hit_q, addr_hit_d;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (clk),
        .reset   (reset),
        .d_i     (scl_in),
        .level_o (scl_lvl_s),
        .rise_o  (scl_rise_s),
        .fall_o  (scl_fall_s)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (clk),
        .reset   (reset),
        .d_i     (sda_in),
        .level_o (sda_lvl_s),
        .rise_o  (sda_rise_s),
        .fall_o  (sda_fall_s)
    );

    assign start_s = scl_lvl_s & sda_fall_s;
    assign stop_s  = scl_lvl_s & sda_rise_s;

    // State, shifter, counter and all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            addr_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            addr_hit_q <= addr_hit_d;
        end
    end

    // Next-state logic; bus conditions outrank SCL edges seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        addr_hit_d = addr_hit_q;

        if (stop_s && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            addr_hit_d = 1'b0;
        end else if (start_s) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 4'd0;
            shift_d    = 8'h00;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b1;
            addr_hit_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_DATA: begin
                    if (scl_rise_s && (bit_cnt_q < BITS_PER_BYTE)) begin
                        shift_d   = {shift_q[6:0], sda_lvl_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_q == BITS_PER_BYTE)) begin
                        if (state_q == ST_DATA) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                            state_d    = ST_DATA_ACK;
                        end else if (addr_match(shift_q, SLAVE_ADDR)) begin
                            sda_oe_d   = 1'b1;
                            addr_hit_d = 1'b1;
                            state_d    = ST_ADDR_ACK;
                        end else begin
                            sda_oe_d   = 1'b0;
                            state_d    = ST_IGNORE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // The first falling edge here ends the ninth (ACK) clock.
                    if (scl_fall_s) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_DATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d    = ST_IDLE;
                    sda_oe_d   = 1'b0;
                    busy_d     = 1'b0;
                    addr_hit_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign addr_hit = addr_hit_q;

endmodule
